// File: rtl/maxpool_window_engine.sv
// maxpool_window_engine: KxK stride-S signed max-pool over a bank-resident map, one CH-lane result per output pixel
module maxpool_window_engine #(
  parameter int IN_W = 111,
  parameter int IN_H = 111,
  parameter int K = 3,
  parameter int S = 2,
  parameter int CH = 64,
  parameter int DW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic [31:0]      rd_addr,
  input  logic [CH*DW-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CH*DW-1:0] out_data,
  output logic [31:0]      out_idx
);
  localparam logic [31:0] OUT_W = 32'((IN_W - K) / S + 1);
  localparam logic [31:0] OUT_H = 32'((IN_H - K) / S + 1);
  localparam logic [31:0] KL = 32'(K);
  localparam logic [31:0] ROW = 32'(IN_W);
  localparam logic [31:0] STEP = 32'(S);
  localparam logic [31:0] ROW_STEP = 32'(S * IN_W);
  typedef enum logic [2:0] {IDLE, READ, DRAIN, EMIT, FIN} state_t;
  state_t state_q, state_d;
  logic [31:0] row_base_q, row_base_d, win_q, win_d, roff_q, roff_d;
  logic [31:0] kr_q, kr_d, kc_q, kc_d, orow_q, orow_d, ocol_q, ocol_d, idx_q, idx_d;
  logic [CH*DW-1:0] acc_q, acc_d;
  logic vld_q, vld_d, first_q, first_d;
  logic last_tap, last_kc, last_col, last_win;
  assign last_kc = kc_q == KL - 1;
  assign last_tap = last_kc && kr_q == KL - 1;
  assign last_col = ocol_q == OUT_W - 1;
  assign last_win = last_col && orow_q == OUT_H - 1;
  assign rd_en = state_q == READ;
  assign rd_addr = rd_en ? win_q + roff_q + kc_q : '0;
  assign busy = state_q inside {READ, DRAIN, EMIT};
  assign done = state_q == FIN;
  assign out_valid = state_q == EMIT;
  assign out_data = acc_q;
  assign out_idx = idx_q;
  // win_q tracks the window's top-left address, row_base_q the first window of the current output row
  always_comb begin
    state_d = state_q;
    row_base_d = row_base_q;
    win_d = win_q;
    roff_d = roff_q;
    kr_d = kr_q;
    kc_d = kc_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    idx_d = idx_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d = READ;
        row_base_d = base_addr;
        win_d = base_addr;
        roff_d = '0;
        kr_d = '0;
        kc_d = '0;
        orow_d = '0;
        ocol_d = '0;
        idx_d = '0;
      end
      READ: begin
        state_d = last_tap ? DRAIN : READ;
        kc_d = last_kc ? '0 : kc_q + 1;
        kr_d = last_tap ? '0 : last_kc ? kr_q + 1 : kr_q;
        roff_d = last_tap ? '0 : last_kc ? roff_q + ROW : roff_q;
      end
      DRAIN: state_d = EMIT;
      EMIT: if (out_ready) begin
        state_d = last_win ? FIN : READ;
        idx_d = idx_q + 1;
        ocol_d = last_col ? '0 : ocol_q + 1;
        orow_d = last_col ? orow_q + 1 : orow_q;
        row_base_d = last_col ? row_base_q + ROW_STEP : row_base_q;
        win_d = last_col ? row_base_q + ROW_STEP : win_q + STEP;
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // data returns one cycle after its read; tap 0 seeds the accumulator, ties keep the older value
  always_comb begin
    vld_d = rd_en;
    first_d = rd_en && kr_q == '0 && kc_q == '0;
    acc_d = acc_q;
    for (int i = 0; i < CH; i++)
      acc_d[i*DW +: DW] = vld_q && (first_q || $signed(rd_data[i*DW +: DW]) > $signed(acc_q[i*DW +: DW]))
                          ? rd_data[i*DW +: DW] : acc_q[i*DW +: DW];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_base_q <= '0;
      win_q <= '0;
      roff_q <= '0;
      kr_q <= '0;
      kc_q <= '0;
      orow_q <= '0;
      ocol_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      vld_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_base_q <= row_base_d;
      win_q <= win_d;
      roff_q <= roff_d;
      kr_q <= kr_d;
      kc_q <= kc_d;
      orow_q <= orow_d;
      ocol_q <= ocol_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      vld_q <= vld_d;
      first_q <= first_d;
    end
  end
endmodule
